fetch_sequencer: RTL and testbench

Instruction-fetch controller for the pipelined CPU. It owns the program counter that addresses the combinational instruction ROM (16-bit `pc` in, 9-bit instruction out: opcode[8:4], operand[3:0]) and registers each fetched word into the IF/ID pipeline register. It also sequences start, stall, branch/jump redirect with flush, and halt drain.

---
 rtl/fetch_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: instruction-fetch controller. Owns the PC driving a
// combinational ROM and registers each fetched word into IF/ID. Sequences
// start, stall, branch/jump redirect with flush, and halt drain.
//
// Ports:
//   clk, reset (async, active-high)
//   start            - begin fetch from IDLE or HALTED
//   stall            - hold PC and IF/ID
//   redirect_valid   - taken branch/jump; redirect_dir 1=fwd, 0=back
//   redirect_base    - PC of branching instruction
//   redirect_offset  - displacement magnitude
//   pc               - ROM address (registered)
//   rom_inst         - ROM data for pc
//   if_inst, if_pc, if_valid - IF/ID register
//   halted           - fetch stopped
//   fetch_count, stall_count - perf counters
//
// Optional feature macro: FETCH_PERF_CNT_EN enables the saturating perf
// counters; without it both counter outputs are tied to zero.

module fetch_sequencer #(
   parameter int          PC_W      = 16,
   parameter int          INST_W    = 9,
   parameter int unsigned RESET_PC  = 1,
   parameter logic [4:0]  HALT_OP   = 5'b11010,
   parameter int          DRAIN_CYC = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stall,
   input  logic              redirect_valid,
   input  logic              redirect_dir,
   input  logic [PC_W-1:0]   redirect_base,
   input  logic [PC_W-1:0]   redirect_offset,
   output logic [PC_W-1:0]   pc,
   input  logic [INST_W-1:0] rom_inst,
   output logic [INST_W-1:0] if_inst,
   output logic [PC_W-1:0]   if_pc,
   output logic              if_valid,
   output logic              halted,
   output logic [15:0]       fetch_count,
   output logic [15:0]       stall_count
);

   localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
   localparam logic [DW-1:0]   D_LAST = DW'(DRAIN_CYC - 1);
   localparam logic [PC_W-1:0] RST_PC = PC_W'(RESET_PC);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_HALTED
   } state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     pc_q, pc_d;
   logic [INST_W-1:0]   inst_q, inst_d;
   logic [PC_W-1:0]     ipc_q, ipc_d;
   logic                valid_q, valid_d;
   logic                halted_q, halted_d;
   logic [DW-1:0]       dcnt_q, dcnt_d;

   logic [PC_W-1:0]     target;
   logic                is_halt;

   // Modulo 2^PC_W arithmetic; carries/borrows are dropped.
   assign target  = redirect_dir ? (redirect_base + redirect_offset)
                                 : (redirect_base - redirect_offset);
   assign is_halt = (rom_inst[INST_W-1 -: 5] == HALT_OP);

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      inst_d   = inst_q;
      ipc_d    = ipc_q;
      valid_d  = valid_q;
      halted_d = halted_q;
      dcnt_d   = dcnt_q;
      unique case (state_q)
         S_IDLE: begin
            pc_d    = RST_PC;
            valid_d = 1'b0;
            if (start) state_d = S_RUN;
         end
         S_RUN: begin
            if (redirect_valid) begin
               pc_d    = target;
               valid_d = 1'b0;
            end else if (!stall) begin
               inst_d  = rom_inst;
               ipc_d   = pc_q;
               valid_d = 1'b1;
               // Halt word: stop advancing the PC and start draining.
               if (is_halt) begin
                  state_d = S_DRAIN;
                  dcnt_d  = '0;
               end else begin
                  pc_d = pc_q + PC_W'(1);
               end
            end
         end
         S_DRAIN: begin
            // A redirect here means the halt was on a wrong path.
            if (redirect_valid) begin
               pc_d    = target;
               valid_d = 1'b0;
               state_d = S_RUN;
            end else if (!stall) begin
               valid_d = 1'b0;
               if (dcnt_q == D_LAST) begin
                  state_d  = S_HALTED;
                  halted_d = 1'b1;
               end else begin
                  dcnt_d = dcnt_q + DW'(1);
               end
            end
         end
         S_HALTED: begin
            valid_d = 1'b0;
            if (start) begin
               pc_d     = RST_PC;
               state_d  = S_RUN;
               halted_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         pc_q     <= RST_PC;
         inst_q   <= '0;
         ipc_q    <= '0;
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         dcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         inst_q   <= inst_d;
         ipc_q    <= ipc_d;
         valid_q  <= valid_d;
         halted_q <= halted_d;
         dcnt_q   <= dcnt_d;
      end
   end

   assign pc       = pc_q;
   assign if_inst  = inst_q;
   assign if_pc    = ipc_q;
   assign if_valid = valid_q;
   assign halted   = halted_q;

`ifdef FETCH_PERF_CNT_EN
   logic [15:0] fcnt_q, fcnt_d;
   logic [15:0] scnt_q, scnt_d;
   logic        run_or_drain;
   logic        fetch_go;
   logic        stall_hit;
   logic        start_go;

   assign run_or_drain = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign fetch_go  = (state_q == S_RUN) && !redirect_valid && !stall;
   assign stall_hit = run_or_drain && stall && !redirect_valid;
   assign start_go  = start &&
                      ((state_q == S_IDLE) || (state_q == S_HALTED));

   always_comb begin
      fcnt_d = fcnt_q;
      scnt_d = scnt_q;
      if (start_go) begin
         fcnt_d = '0;
         scnt_d = '0;
      end else begin
         if (fetch_go && fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
         if (stall_hit && scnt_q != 16'hFFFF) scnt_d = scnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fcnt_q <= '0;
         scnt_q <= '0;
      end else begin
         fcnt_q <= fcnt_d;
         scnt_q <= scnt_d;
      end
   end

   assign fetch_count = fcnt_q;
   assign stall_count = scnt_q;
`else
   assign fetch_count = 16'd0;
   assign stall_count = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed self-checking bench for fetch_sequencer.
// Drives a model ROM, walks start/stall/redirect/halt/reset scenarios.

module tb_fetch_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        start = 1'b0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic        redirect_dir = 1'b0;
   logic [15:0] redirect_base = '0;
   logic [15:0] redirect_offset = '0;
   logic [15:0] pc;
   logic [8:0]  rom_inst;
   logic [8:0]  if_inst;
   logic [15:0] if_pc;
   logic        if_valid;
   logic        halted;
   logic [15:0] fetch_count;
   logic [15:0] stall_count;
   logic        halt_en = 1'b0;

   int errors = 0;
   int checks = 0;

   fetch_sequencer dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .stall           (stall),
      .redirect_valid  (redirect_valid),
      .redirect_dir    (redirect_dir),
      .redirect_base   (redirect_base),
      .redirect_offset (redirect_offset),
      .pc              (pc),
      .rom_inst        (rom_inst),
      .if_inst         (if_inst),
      .if_pc           (if_pc),
      .if_valid        (if_valid),
      .halted          (halted),
      .fetch_count     (fetch_count),
      .stall_count     (stall_count)
   );

   always #5 clk = ~clk;

   // Model ROM: opcode never equals the halt opcode except at address 74
   // when halt_en is set.
   function automatic logic [8:0] rom(input logic [15:0] a, input logic he);
      if (he && a == 16'd74) return {5'b11010, 4'h0};
      return {1'b0, a[3:0], a[7:4]};
   endfunction

   always_comb rom_inst = rom(pc, halt_en);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic redir(input logic d, input logic [15:0] b,
                        input logic [15:0] o);
      redirect_valid  = 1'b1;
      redirect_dir    = d;
      redirect_base   = b;
      redirect_offset = o;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_pc"}, 32'(pc), 32'd1);
      chk({tag, "_inst"}, 32'(if_inst), 32'd0);
      chk({tag, "_ifpc"}, 32'(if_pc), 32'd0);
      chk({tag, "_valid"}, 32'(if_valid), 32'd0);
      chk({tag, "_halted"}, 32'(halted), 32'd0);
      chk({tag, "_fcnt"}, 32'(fetch_count), 32'd0);
      chk({tag, "_scnt"}, 32'(stall_count), 32'd0);
   endtask

   initial begin
      reset = 1'b1;
      tick();
      chk_reset_vals("rst");
      reset = 1'b0;

      // IDLE ignores stall and redirect
      redir(1'b1, 16'd100, 16'd5);
      stall = 1'b1;
      tick();
      chk("idle_pc", 32'(pc), 32'd1);
      chk("idle_valid", 32'(if_valid), 32'd0);
      redirect_valid = 1'b0;
      stall = 1'b0;

      // start: no fetch in the transition cycle
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_pc", 32'(pc), 32'd1);
      chk("start_valid", 32'(if_valid), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         tick();
         chk("seq_ifpc", 32'(if_pc), 32'(i));
         chk("seq_inst", 32'(if_inst), 32'(rom(16'(i), 1'b0)));
         chk("seq_valid", 32'(if_valid), 32'd1);
      end
      chk("seq_pc", 32'(pc), 32'd6);

      // Stall 3 cycles at pc=6
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("stall_pc", 32'(pc), 32'd6);
         chk("stall_inst", 32'(if_inst), 32'(rom(16'd5, 1'b0)));
      end
      chk("stall_ifpc", 32'(if_pc), 32'd5);
      chk("stall_valid", 32'(if_valid), 32'd1);
`ifdef FETCH_PERF_CNT_EN
      chk("stall_cnt", 32'(stall_count), 32'd3);
      chk("fetch_cnt", 32'(fetch_count), 32'd5);
`else
      chk("stall_cnt_off", 32'(stall_count), 32'd0);
      chk("fetch_cnt_off", 32'(fetch_count), 32'd0);
`endif

      // Forward redirect coincident with stall
      redir(1'b1, 16'd60, 16'd8);
      tick();
      redirect_valid = 1'b0;
      stall = 1'b0;
      chk("fwd_pc", 32'(pc), 32'd68);
      chk("fwd_bubble", 32'(if_valid), 32'd0);
      chk("fwd_ifpc_hold", 32'(if_pc), 32'd5);
`ifdef FETCH_PERF_CNT_EN
      chk("fwd_scnt", 32'(stall_count), 32'd3);
`endif
      tick();
      chk("fwd_ifpc", 32'(if_pc), 32'd68);
      chk("fwd_valid", 32'(if_valid), 32'd1);
      chk("fwd_pc2", 32'(pc), 32'd69);

      // Backward redirects
      redir(1'b0, 16'd73, 16'd57);
      tick();
      redirect_valid = 1'b0;
      chk("back_pc", 32'(pc), 32'd16);
      chk("back_bubble", 32'(if_valid), 32'd0);
      tick();
      chk("back_ifpc", 32'(if_pc), 32'd16);
      redir(1'b0, 16'd2, 16'd5);
      tick();
      redirect_valid = 1'b0;
      chk("back_wrap_pc", 32'(pc), 32'hFFFD);
      tick();
      chk("wrap_ifpc0", 32'(if_pc), 32'hFFFD);
      tick();
      tick();
      chk("wrap_ifpc", 32'(if_pc), 32'hFFFF);
      chk("wrap_inst", 32'(if_inst), 32'(rom(16'hFFFF, 1'b0)));
      chk("wrap_pc", 32'(pc), 32'h0000);
      redir(1'b1, 16'hFFFE, 16'd3);
      tick();
      chk("fwd_wrap_pc", 32'(pc), 32'h0001);

      // Halt at 74, no stall
      halt_en = 1'b1;
      redir(1'b1, 16'd70, 16'd4);
      tick();
      redirect_valid = 1'b0;
      chk("h_pc", 32'(pc), 32'd74);
      tick();
      chk("h_inst", 32'(if_inst), 32'h1A0);
      chk("h_ifpc", 32'(if_pc), 32'd74);
      chk("h_valid", 32'(if_valid), 32'd1);
      chk("h_pc_hold", 32'(pc), 32'd74);
      chk("h_halted0", 32'(halted), 32'd0);
      tick();
      chk("h_drain_valid", 32'(if_valid), 32'd0);
      chk("h_halted1", 32'(halted), 32'd0);
      tick();
      chk("h_halted2", 32'(halted), 32'd0);
      tick();
      chk("h_halted3", 32'(halted), 32'd1);
      chk("h_valid3", 32'(if_valid), 32'd0);

      // HALTED ignores redirect and stall
      redir(1'b1, 16'd10, 16'd10);
      stall = 1'b1;
      tick();
      redirect_valid = 1'b0;
      stall = 1'b0;
      chk("hd_pc", 32'(pc), 32'd74);
      chk("hd_halted", 32'(halted), 32'd1);

      // Restart from HALTED
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rs_pc", 32'(pc), 32'd1);
      chk("rs_halted", 32'(halted), 32'd0);
      chk("rs_valid", 32'(if_valid), 32'd0);
      tick();
      chk("rs_ifpc", 32'(if_pc), 32'd1);
      chk("rs_valid2", 32'(if_valid), 32'd1);
`ifdef FETCH_PERF_CNT_EN
      chk("rs_fcnt", 32'(fetch_count), 32'd1);
      chk("rs_scnt", 32'(stall_count), 32'd0);
`endif

      // Halt cancelled by redirect during drain
      redir(1'b1, 16'd70, 16'd4);
      tick();
      redirect_valid = 1'b0;
      tick();
      chk("hc_ifpc", 32'(if_pc), 32'd74);
      redir(1'b1, 16'd74, 16'd10);
      tick();
      redirect_valid = 1'b0;
      chk("hc_pc", 32'(pc), 32'd84);
      chk("hc_valid", 32'(if_valid), 32'd0);
      tick();
      chk("hc_ifpc2", 32'(if_pc), 32'd84);
      chk("hc_valid2", 32'(if_valid), 32'd1);
      tick();
      tick();
      chk("hc_halted", 32'(halted), 32'd0);
      chk("hc_ifpc3", 32'(if_pc), 32'd86);

      // Async reset mid-RUN, checked before the next edge
      #2;
      reset = 1'b1;
      #1;
      chk_reset_vals("arst");
      #2;
      reset = 1'b0;
      tick();
      chk("arst_idle_pc", 32'(pc), 32'd1);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk("arst_ifpc", 32'(if_pc), 32'd1);
      chk("arst_valid", 32'(if_valid), 32'd1);
      chk("arst_pc", 32'(pc), 32'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
